sdram_ctrl: RTL and testbench

SDRAM_CTRL -- requirements
Module: sdram_ctrl

---
 rtl/sdram_pkg.sv | 31 +++
 rtl/sdram_cmd_timer.sv | 26 ++
 rtl/sdram_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_sdram_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared constants for the single-word SDRAM controller:
// command encodings, FSM state codes and address field widths.
package sdram_pkg;

    localparam int ROW_W  = 13;
    localparam int COL_W  = 9;
    localparam int BANK_W = 2;
    localparam int ADDR_W = BANK_W + ROW_W + COL_W;

    // {csn, rasn, casn, wen}
    localparam logic [3:0] CMD_DESL  = 4'b1111;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_MRS   = 4'b0000;

    localparam logic [3:0] S_INIT_WAIT = 4'd0;
    localparam logic [3:0] S_INIT_PRE  = 4'd1;
    localparam logic [3:0] S_INIT_REF1 = 4'd2;
    localparam logic [3:0] S_INIT_REF2 = 4'd3;
    localparam logic [3:0] S_INIT_MRS  = 4'd4;
    localparam logic [3:0] S_IDLE      = 4'd5;
    localparam logic [3:0] S_ACTIVATE  = 4'd6;
    localparam logic [3:0] S_ACCESS    = 4'd7;
    localparam logic [3:0] S_WAIT      = 4'd8;
    localparam logic [3:0] S_REFRESH   = 4'd9;

endpackage

// File: rtl/sdram_cmd_timer.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module sdram_cmd_timer #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/sdram_ctrl.sv
// Single-word SDRAM controller: power-up init, one request in flight,
// auto-precharge accesses and deferred periodic refresh.
module sdram_ctrl #(
    parameter int CAS_LATENCY    = 2,
    parameter int T_RCD          = 1,
    parameter int T_RP           = 1,
    parameter int T_WR           = 2,
    parameter int T_RFC          = 3,
    parameter int INIT_CYCLES    = 8334,
    parameter int REFRESH_CYCLES = 325
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [23:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic [1:0]  req_mask,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    input  logic [15:0] out_sdram_din_0,
    output logic [15:0] out_sdram_dout,
    output logic        out_sdram_den,
    output logic        out_sdram_csn,
    output logic        out_sdram_rasn,
    output logic        out_sdram_casn,
    output logic        out_sdram_wen,
    output logic [12:0] out_sdram_a,
    output logic [1:0]  out_sdram_ba,
    output logic [1:0]  out_sdram_dqm
);

    import sdram_pkg::*;

    // Timer loads are one less than the wait: the new state's command
    // occupies the first cycle of that wait.
    localparam logic [15:0] LD_INIT = 16'(INIT_CYCLES - 2);
    localparam logic [15:0] LD_RP   = 16'(T_RP - 1);
    localparam logic [15:0] LD_RFC  = 16'(T_RFC - 1);
    localparam logic [15:0] LD_RCD  = 16'(T_RCD - 1);
    localparam logic [15:0] LD_MRS  = 16'd1;
    localparam logic [15:0] LD_RD   = 16'(CAS_LATENCY + T_RP - 1);
    localparam logic [15:0] LD_WR   = 16'(T_WR + T_RP - 1);
    localparam logic [15:0] REF_LAST = 16'(REFRESH_CYCLES - 1);
    localparam logic [12:0] MRS_A   = 13'(CAS_LATENCY << 4);

    logic [3:0]        state, nxt_state;
    logic              init_armed;
    logic              tmr_load, tmr_done;
    logic [15:0]       tmr_val;
    logic [3:0]        cmd, nxt_cmd;
    logic [12:0]       nxt_a;
    logic [1:0]        nxt_ba, nxt_dqm;
    logic              nxt_den;
    logic [15:0]       nxt_dout;
    logic              accept, ref_issue, ref_wrap, in_init;
    logic              acc_write;
    logic [BANK_W-1:0] acc_ba;
    logic [COL_W-1:0]  acc_col;
    logic [15:0]       acc_wdata;
    logic [1:0]        acc_mask;
    logic [15:0]       ref_cnt;
    logic              ref_pending;
    logic [CAS_LATENCY:0] rd_pipe;
    logic [15:0]       rd_cap;

    sdram_cmd_timer #(.W(16)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    assign in_init   = state inside {S_INIT_WAIT, S_INIT_PRE,
                                     S_INIT_REF1, S_INIT_REF2, S_INIT_MRS};
    assign ref_wrap  = !in_init && (ref_cnt == REF_LAST);
    assign req_ready = (state == S_IDLE) && !ref_pending;

    assign {out_sdram_csn, out_sdram_rasn,
            out_sdram_casn, out_sdram_wen} = cmd;

    always_comb begin
        nxt_state = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        nxt_cmd   = CMD_NOP;
        nxt_a     = '0;
        nxt_ba    = '0;
        nxt_dqm   = 2'b11;
        nxt_den   = 1'b0;
        nxt_dout  = '0;
        accept    = 1'b0;
        ref_issue = 1'b0;
        case (state)
            S_INIT_WAIT: begin
                if (!init_armed) begin
                    tmr_load = 1'b1;
                    tmr_val  = LD_INIT;
                end else if (tmr_done) begin
                    nxt_state = S_INIT_PRE;
                    nxt_cmd   = CMD_PRE;
                    nxt_a[10] = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_val   = LD_RP;
                end
            end
            S_INIT_PRE, S_INIT_REF1: if (tmr_done) begin
                nxt_state = (state == S_INIT_PRE) ? S_INIT_REF1 : S_INIT_REF2;
                nxt_cmd   = CMD_REF;
                tmr_load  = 1'b1;
                tmr_val   = LD_RFC;
            end
            S_INIT_REF2: if (tmr_done) begin
                nxt_state = S_INIT_MRS;
                nxt_cmd   = CMD_MRS;
                nxt_a     = MRS_A;
                tmr_load  = 1'b1;
                tmr_val   = LD_MRS;
            end
            S_IDLE: begin
                if (ref_pending) begin
                    nxt_state = S_REFRESH;
                    nxt_cmd   = CMD_REF;
                    tmr_load  = 1'b1;
                    tmr_val   = LD_RFC;
                    ref_issue = 1'b1;
                end else if (req_valid) begin
                    nxt_state = S_ACTIVATE;
                    nxt_cmd   = CMD_ACT;
                    nxt_ba    = req_addr[ADDR_W-1 -: BANK_W];
                    nxt_a     = req_addr[COL_W +: ROW_W];
                    tmr_load  = 1'b1;
                    tmr_val   = LD_RCD;
                    accept    = 1'b1;
                end
            end
            S_ACTIVATE: if (tmr_done) begin
                nxt_state = S_ACCESS;
                nxt_cmd   = acc_write ? CMD_WRITE : CMD_READ;
                nxt_ba    = acc_ba;
                nxt_a     = {2'b00, 1'b1, 1'b0, acc_col};
                nxt_dqm   = acc_write ? ~acc_mask : 2'b00;
                nxt_den   = acc_write;
                nxt_dout  = acc_write ? acc_wdata : 16'h0000;
            end
            S_ACCESS: begin
                nxt_state = S_WAIT;
                tmr_load  = 1'b1;
                tmr_val   = acc_write ? LD_WR : LD_RD;
            end
            S_INIT_MRS, S_WAIT, S_REFRESH: if (tmr_done) begin
                nxt_state = S_IDLE;
            end
            default: nxt_state = S_INIT_WAIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_INIT_WAIT;
            init_armed     <= 1'b0;
            cmd            <= CMD_DESL;
            out_sdram_a    <= '0;
            out_sdram_ba   <= '0;
            out_sdram_dqm  <= 2'b11;
            out_sdram_den  <= 1'b0;
            out_sdram_dout <= '0;
            acc_write      <= 1'b0;
            acc_ba         <= '0;
            acc_col        <= '0;
            acc_wdata      <= '0;
            acc_mask       <= '0;
            ref_cnt        <= '0;
            ref_pending    <= 1'b0;
            rd_pipe        <= '0;
            rd_cap         <= '0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
        end else begin
            state          <= nxt_state;
            init_armed     <= 1'b1;
            cmd            <= nxt_cmd;
            out_sdram_a    <= nxt_a;
            out_sdram_ba   <= nxt_ba;
            out_sdram_dqm  <= nxt_dqm;
            out_sdram_den  <= nxt_den;
            out_sdram_dout <= nxt_dout;
            if (accept) begin
                acc_write <= req_write;
                acc_ba    <= req_addr[ADDR_W-1 -: BANK_W];
                acc_col   <= req_addr[COL_W-1:0];
                acc_wdata <= req_wdata;
                acc_mask  <= req_mask;
            end
            if (ref_wrap) begin
                ref_cnt <= '0;
            end else if (!in_init) begin
                ref_cnt <= ref_cnt + 16'd1;
            end
            // A wrap coinciding with REF issue still leaves one refresh owed
            if (ref_wrap) begin
                ref_pending <= 1'b1;
            end else if (ref_issue) begin
                ref_pending <= 1'b0;
            end
            rd_pipe <= {rd_pipe[CAS_LATENCY-1:0],
                        (state == S_ACCESS) && !acc_write};
            if (rd_pipe[CAS_LATENCY-1]) begin
                rd_cap <= out_sdram_din_0;
            end
            rsp_valid <= rd_pipe[CAS_LATENCY];
            if (rd_pipe[CAS_LATENCY]) begin
                rsp_data <= rd_cap;
            end
        end
    end

endmodule

// File: tb/tb_sdram_ctrl.sv
// Directed bench for sdram_ctrl with a small behavioural SDRAM model
// that also flags bank-state protocol errors.
module tb_sdram_ctrl;

    localparam int CL   = 2;
    localparam int TRCD = 1;
    localparam int TRP  = 1;
    localparam int TWR  = 2;
    localparam int TRFC = 3;
    localparam int INIT = 10;
    localparam int REFC = 40;

    localparam logic [3:0] C_NOP   = 4'b0111;
    localparam logic [3:0] C_ACT   = 4'b0011;
    localparam logic [3:0] C_READ  = 4'b0101;
    localparam logic [3:0] C_WRITE = 4'b0100;
    localparam logic [3:0] C_PRE   = 4'b0010;
    localparam logic [3:0] C_REF   = 4'b0001;
    localparam logic [3:0] C_MRS   = 4'b0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [23:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_mask = '0;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic [15:0] din = 16'hDEAD;
    logic [15:0] dout;
    logic        den, csn, rasn, casn, wen;
    logic [12:0] a;
    logic [1:0]  ba, dqm;
    logic [3:0]  cmd;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    assign cmd = {csn, rasn, casn, wen};

    sdram_ctrl #(
        .CAS_LATENCY(CL), .T_RCD(TRCD), .T_RP(TRP), .T_WR(TWR),
        .T_RFC(TRFC), .INIT_CYCLES(INIT), .REFRESH_CYCLES(REFC)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_mask(req_mask),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .out_sdram_din_0(din), .out_sdram_dout(dout),
        .out_sdram_den(den), .out_sdram_csn(csn),
        .out_sdram_rasn(rasn), .out_sdram_casn(casn),
        .out_sdram_wen(wen), .out_sdram_a(a),
        .out_sdram_ba(ba), .out_sdram_dqm(dqm)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // SDRAM model: commands sampled mid-cycle, read data driven CL
    // negedges later so it is stable across the controller's capture edge.
    logic [15:0] mem [int];
    logic [12:0] open_row [4];
    logic [3:0]  open_b = '0;
    logic [15:0] dq [CL+1];

    always @(negedge clock) begin
        logic [15:0] rdv;
        logic [15:0] v;
        int key;
        rdv = 16'hDEAD;
        if (reset) begin
            open_b = '0;
        end else begin
            chk("den_only_on_write", den, cmd == C_WRITE);
            key = int'({8'h00, ba, open_row[ba], a[8:0]});
            case (cmd)
                C_ACT: begin
                    chk("model_act_bank_idle", open_b[ba], 1'b0);
                    open_b[ba]   = 1'b1;
                    open_row[ba] = a;
                end
                C_WRITE: begin
                    chk("model_wr_bank_open", open_b[ba], 1'b1);
                    v = mem.exists(key) ? mem[key] : 16'h0000;
                    if (!dqm[0]) v[7:0]  = dout[7:0];
                    if (!dqm[1]) v[15:8] = dout[15:8];
                    mem[key] = v;
                    open_b[ba] = 1'b0;
                end
                C_READ: begin
                    chk("model_rd_bank_open", open_b[ba], 1'b1);
                    rdv = mem.exists(key) ? mem[key] : 16'h0000;
                    open_b[ba] = 1'b0;
                end
                C_REF: chk("model_ref_all_idle", open_b, 4'h0);
                default: ;
            endcase
        end
        for (int k = CL; k > 0; k--) dq[k] = dq[k-1];
        dq[0] = rdv;
        din = dq[CL];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reset();
        chk("rst_cmd", cmd, 4'hF);
        chk("rst_a", a, 13'h0);
        chk("rst_ba", ba, 2'b00);
        chk("rst_dqm", dqm, 2'b11);
        chk("rst_den", den, 1'b0);
        chk("rst_dout", dout, 16'h0);
        chk("rst_ready", req_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 16'h0);
    endtask

    // Called at #1 after the last edge with reset high; reset is released here.
    task automatic run_init();
        int pre, r1, r2, mrs, idle;
        logic [3:0] e;
        pre  = INIT;
        r1   = pre + TRP;
        r2   = r1 + TRFC;
        mrs  = r2 + TRFC;
        idle = mrs + 2;
        reset = 1'b0;
        for (int n = 1; n <= idle; n++) begin
            tick();
            e = (n == pre) ? C_PRE :
                (n == r1 || n == r2) ? C_REF :
                (n == mrs) ? C_MRS : C_NOP;
            chk($sformatf("init_cmd_%0d", n), cmd, e);
            chk($sformatf("init_ready_%0d", n), req_ready, n == idle);
            if (n < pre) chk("init_dqm", dqm, 2'b11);
            if (n == pre) chk("init_pre_a10", a[10], 1'b1);
            if (n == mrs) chk("init_mrs_a", a, 13'h020);
        end
    endtask

    task automatic issue(input logic w, input logic [23:0] ad,
                         input logic [15:0] d, input logic [1:0] m);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = ad;
        req_wdata = d;
        req_mask  = m;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        chk("handshake_ready", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        chk("act_cmd", cmd, C_ACT);
        chk("act_ba", ba, ad[23:22]);
        chk("act_row", a, ad[21:9]);
        chk("no_ready_in_flight", req_ready, 1'b0);
        repeat (TRCD) tick();
        chk("rw_ba", ba, ad[23:22]);
        chk("rw_a", a, {2'b00, 1'b1, 1'b0, ad[8:0]});
    endtask

    task automatic do_write(input logic [23:0] ad, input logic [15:0] d,
                            input logic [1:0] m);
        logic [1:0] nm;
        nm = ~m;
        issue(1'b1, ad, d, m);
        chk("wr_cmd", cmd, C_WRITE);
        chk("wr_den", den, 1'b1);
        chk("wr_dout", dout, d);
        chk("wr_dqm", dqm, nm);
        tick();
        chk("wr_den_off", den, 1'b0);
    endtask

    task automatic do_read(input logic [23:0] ad, input logic [15:0] exp);
        int n;
        issue(1'b0, ad, 16'h0, 2'b00);
        chk("rd_cmd", cmd, C_READ);
        chk("rd_dqm", dqm, 2'b00);
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk("rd_latency", n, CL + 2);
        chk("rd_data", rsp_data, exp);
        tick();
        chk("rsp_single_pulse", rsp_valid, 1'b0);
        chk("rsp_data_held", rsp_data, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int ref_at, rdy_at, rsp_at;
        repeat (3) tick();
        chk_reset();
        run_init();

        do_write(24'h012345, 16'hBEEF, 2'b11);
        do_read(24'h012345, 16'hBEEF);

        do_write(24'h0A0010, 16'h1234, 2'b11);
        do_write(24'h0A0010, 16'hABCD, 2'b01);
        do_read(24'h0A0010, 16'h12CD);

        do_write({2'b01, 13'h0005, 9'h007}, 16'h1111, 2'b11);
        do_write({2'b10, 13'h0005, 9'h007}, 16'h2222, 2'b11);
        do_read({2'b01, 13'h0005, 9'h007}, 16'h1111);
        do_read({2'b10, 13'h0005, 9'h007}, 16'h2222);

        // Fresh init so the refresh expiry lands inside a read
        reset = 1'b1;
        tick();
        chk_reset();
        run_init();
        repeat (REFC - 4) tick();
        issue(1'b0, 24'h0A0010, 16'h0, 2'b00);
        chk("refr_rd_cmd", cmd, C_READ);
        ref_at = -1;
        rdy_at = -1;
        rsp_at = -1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (cmd == C_REF && ref_at < 0) ref_at = t;
            if (req_ready && rdy_at < 0) rdy_at = t;
            if (rsp_valid) begin
                rsp_at = t;
                chk("refr_rd_data", rsp_data, 16'h12CD);
            end
        end
        chk("refr_rsp_at", rsp_at, CL + 2);
        chk("refr_ref_after_wait",
            (ref_at == 1 + CL + TRP) || (ref_at == 2 + CL + TRP), 1'b1);
        chk("refr_ready_after_trfc", rdy_at, ref_at + TRFC);

        // Reset on the READ cycle aborts the response
        issue(1'b0, {2'b01, 13'h0005, 9'h007}, 16'h0, 2'b00);
        chk("abort_rd_cmd", cmd, C_READ);
        reset = 1'b1;
        tick();
        chk_reset();
        for (int t = 0; t < 6; t++) begin
            tick();
            chk("abort_no_rsp", rsp_valid, 1'b0);
        end
        run_init();
        do_read({2'b01, 13'h0005, 9'h007}, 16'h1111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
